// File: rtl/correlator_pkg.sv
// Shared types and sizing helpers for the correlator snapshot framer.
package correlator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int unsigned bytes_per_word(input int unsigned resolution);
    return (resolution + 7) / 8;
  endfunction

  function automatic int unsigned payload_bytes(input int unsigned resolution,
                                                input int unsigned num_words);
    return num_words * bytes_per_word(resolution);
  endfunction

endpackage

// File: rtl/frame_byte_select.sv
// Combinational payload byte selector: maps a payload byte index onto the
// shadowed counter vector, each word little-endian with zero-padded upper byte.
module frame_byte_select
  import correlator_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned NUM_WORDS  = 28,
  parameter int unsigned IDX_W      = 1
) (
  input  logic [NUM_WORDS*RESOLUTION-1:0] shadow,
  input  logic [IDX_W-1:0]                idx,
  output logic [7:0]                      data_byte
);

  localparam int unsigned BPW = bytes_per_word(RESOLUTION);
  localparam int unsigned PB  = payload_bytes(RESOLUTION, NUM_WORDS);

  // Each word is widened to a whole number of bytes so byte k sits at [k*8 +: 8].
  logic [PB*8-1:0] padded;

  always_comb begin
    padded = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      padded[w*BPW*8 +: RESOLUTION] = shadow[w*RESOLUTION +: RESOLUTION];
    end
  end

  always_comb begin
    data_byte = '0;
    for (int unsigned b = 0; b < PB; b++) begin
      if (idx == IDX_W'(b)) data_byte = padded[b*8 +: 8];
    end
  end

endmodule

// File: rtl/correlator_frame_tx.sv
// Snapshot framer: captures the counter vector on a strobe and emits
// SYNC, seq, payload and an 8-bit checksum over a valid/ready byte port.
module correlator_frame_tx
  import correlator_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned NUM_WORDS  = 28,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WORDS*RESOLUTION-1:0] snap_data,
  input  logic                          snap_strobe,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_byte,
  output logic                          tx_valid,
  output logic                          busy,
  output logic [7:0]                    overrun_count
);

  localparam int unsigned PB     = payload_bytes(RESOLUTION, NUM_WORDS);
  localparam int unsigned IDX_W  = (PB > 1) ? $clog2(PB) : 1;
  localparam int unsigned SNAP_W = NUM_WORDS * RESOLUTION;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PB - 1);

  state_t            state, state_next;
  logic [SNAP_W-1:0] shadow, shadow_next;
  logic [7:0]        seq, seq_next;
  logic [7:0]        acc, acc_next;
  logic [7:0]        tx_byte_next, overrun_next;
  logic [IDX_W-1:0]  idx, idx_next, sel_idx;
  logic              tx_valid_next;
  logic              handshake;
  logic [7:0]        sel_byte;

  assign handshake = tx_valid && tx_ready;
  assign busy      = (state != IDLE);

  // The selector looks one byte ahead so the next byte can be registered
  // at the current handshake; in SEQ it supplies payload byte 0.
  assign sel_idx = (state == PAYLOAD) ? idx + IDX_W'(1) : '0;

  frame_byte_select #(
    .RESOLUTION(RESOLUTION),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_sel (
    .shadow   (shadow),
    .idx      (sel_idx),
    .data_byte(sel_byte)
  );

  always_comb begin
    state_next    = state;
    shadow_next   = shadow;
    seq_next      = seq;
    acc_next      = acc;
    idx_next      = idx;
    tx_byte_next  = tx_byte;
    tx_valid_next = tx_valid;
    overrun_next  = overrun_count;

    if (snap_strobe && (state != IDLE) && (overrun_count != 8'hFF)) begin
      overrun_next = overrun_count + 8'd1;
    end

    case (state)
      IDLE: begin
        if (snap_strobe) begin
          shadow_next   = snap_data;
          state_next    = SYNC;
          acc_next      = '0;
          idx_next      = '0;
          tx_byte_next  = SYNC_BYTE;
          tx_valid_next = 1'b1;
        end
      end
      SYNC: begin
        if (handshake) begin
          state_next   = SEQ;
          tx_byte_next = seq;
        end
      end
      SEQ: begin
        if (handshake) begin
          state_next   = PAYLOAD;
          acc_next     = acc + tx_byte;
          tx_byte_next = sel_byte;
        end
      end
      PAYLOAD: begin
        if (handshake) begin
          acc_next = acc + tx_byte;
          if (idx == LAST_IDX) begin
            state_next   = CSUM;
            tx_byte_next = acc + tx_byte;
          end else begin
            idx_next     = idx + IDX_W'(1);
            tx_byte_next = sel_byte;
          end
        end
      end
      CSUM: begin
        if (handshake) begin
          state_next    = IDLE;
          seq_next      = seq + 8'd1;
          idx_next      = '0;
          tx_byte_next  = '0;
          tx_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shadow        <= '0;
      seq           <= '0;
      acc           <= '0;
      idx           <= '0;
      tx_byte       <= '0;
      tx_valid      <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_next;
      shadow        <= shadow_next;
      seq           <= seq_next;
      acc           <= acc_next;
      idx           <= idx_next;
      tx_byte       <= tx_byte_next;
      tx_valid      <= tx_valid_next;
      overrun_count <= overrun_next;
    end
  end

endmodule
